// File: rtl/exp_series_engine_pkg.sv
// Shared constants, widths and FSM state type for the exp_series_engine slice.
package exp_pkg;

    localparam int X_W    = 8;
    localparam int ACC_W  = 16;
    localparam int LUT_AW = 4;

    localparam logic [ACC_W-1:0] ONE_Q2_14 = 16'h4000;
    localparam logic [ACC_W-1:0] SAT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } exp_state_t;

endpackage

// File: rtl/exp_series_engine_if.sv
// Operand/result handshake bundle; master = producer/consumer side, slave = engine.
interface exp_series_engine_if;
    import exp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   x_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/exp_series_engine_term_step.sv
// One Taylor iteration: nterm = ((term*x)>>8 * recip)>>8, plus saturating accumulate.
module exp_term_step
    import exp_pkg::*;
(
    input  logic [ACC_W-1:0] term,
    input  logic [ACC_W-1:0] sum,
    input  logic [X_W-1:0]   x,
    input  logic [X_W-1:0]   recip,
    output logic [ACC_W-1:0] nterm,
    output logic [ACC_W-1:0] sat_sum
);

    logic [23:0]      p1_full;
    logic [23:0]      p2_full;
    logic [ACC_W:0]   sum_full;

    // Both products keep bits [23:8]: plain truncation, no rounding.
    always_comb begin
        p1_full  = 24'(term) * 24'(x);
        p2_full  = 24'(p1_full[23:8]) * 24'(recip);
        nterm    = p2_full[23:8];
        sum_full = {1'b0, sum} + {1'b0, nterm};
        sat_sum  = sum_full[ACC_W] ? SAT_MAX : sum_full[ACC_W-1:0];
    end

endmodule

// File: rtl/exp_series_engine.sv
// Iterative e^x Taylor engine (Q0.8 in, Q2.14 out), one term per clock.
// Optional EARLY_EXIT_EN: stop when a term underflows to zero and report terms_used.
module exp_series_engine
    import exp_pkg::*;
#(
    parameter int N_TERMS = 8
) (
    input  logic                clk,
    input  logic                rst,
    exp_series_engine_if.slave  bus,
    output logic [LUT_AW-1:0]   lut_addr,
    input  logic [X_W-1:0]      lut_data
`ifdef EARLY_EXIT_EN
    ,
    output logic [4:0]          terms_used
`endif
);

    exp_state_t       state_q, state_d;
    logic [4:0]       k_q, k_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [ACC_W-1:0] term_q, term_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
`ifdef EARLY_EXIT_EN
    logic [4:0]       terms_q, terms_d;
`endif

    logic [ACC_W-1:0] nterm;
    logic [ACC_W-1:0] sat_sum;
    logic             calc_exit;

    exp_term_step u_step (
        .term    (term_q),
        .sum     (sum_q),
        .x       (x_q),
        .recip   (lut_data),
        .nterm   (nterm),
        .sat_sum (sat_sum)
    );

`ifdef EARLY_EXIT_EN
    assign calc_exit = (k_q == 5'(N_TERMS - 1)) || (nterm == '0);
`else
    assign calc_exit = (k_q == 5'(N_TERMS - 1));
`endif

    // NOTE: reset is synchronous here, so it lives inside the clocked block with no sensitivity on rst.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = CALC;
            CALC:    if (calc_exit) state_d = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
        lut_addr      = k_q[LUT_AW-1:0];
`ifdef EARLY_EXIT_EN
        terms_used    = terms_q;
`endif
    end

    // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
    always_comb begin
        k_d         = k_q;
        x_d         = x_q;
        term_d      = term_q;
        sum_d       = sum_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef EARLY_EXIT_EN
        terms_d     = terms_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d    = bus.x_in;
                    term_d = ONE_Q2_14;
                    sum_d  = ONE_Q2_14;
                    k_d    = '0;
                end
            end
            CALC: begin
                term_d = nterm;
                sum_d  = sat_sum;
                k_d    = k_q + 5'd1;
            end
            DONE: begin
                // First DONE cycle latches the sum; out_valid then holds until consumed.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    result_d    = sum_q;
`ifdef EARLY_EXIT_EN
                    terms_d     = k_q;
`endif
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q         <= '0;
            x_q         <= '0;
            term_q      <= '0;
            sum_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef EARLY_EXIT_EN
            terms_q     <= '0;
`endif
        end else begin
            k_q         <= k_d;
            x_q         <= x_d;
            term_q      <= term_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
`ifdef EARLY_EXIT_EN
            terms_q     <= terms_d;
`endif
        end
    end

endmodule

// File: tb/tb_exp_series_engine.sv
// Scoreboard bench for exp_series_engine: directed operands, Q0.8 reciprocal LUT model,
// bit-accurate golden model; a negedge monitor pops expected results on each output handshake.
module tb_exp_series_engine;
    import exp_pkg::*;

    localparam int N       = 8;
    localparam int TIMEOUT = 100;

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  terms;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exp_series_engine_if bus ();

    logic [3:0] lut_addr;
    logic [7:0] lut_data;
    logic [7:0] lut [16];
`ifdef EARLY_EXIT_EN
    logic [4:0] terms_used;
`endif

    assign lut_data = lut[lut_addr];

    exp_series_engine #(.N_TERMS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .lut_addr   (lut_addr),
        .lut_data   (lut_data)
`ifdef EARLY_EXIT_EN
        ,
        .terms_used (terms_used)
`endif
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-accurate series model using the same LUT contents the DUT sees.
    function automatic void golden(input logic [7:0] x, output logic [15:0] res,
                                   output logic [4:0] iters);
        logic [15:0] term, sum, p1, nt;
        logic [23:0] p;
        logic [16:0] s;
        term  = 16'h4000;
        sum   = 16'h4000;
        iters = '0;
        for (int k = 0; k < N; k++) begin
            p     = 24'(term) * 24'(x);
            p1    = p[23:8];
            p     = 24'(p1) * 24'(lut[k]);
            nt    = p[23:8];
            s     = 17'(sum) + 17'(nt);
            sum   = s[16] ? 16'hFFFF : s[15:0];
            term  = nt;
            iters = 5'(k + 1);
`ifdef EARLY_EXIT_EN
            if (nt == 16'h0) break;
`endif
        end
        res = sum;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", 32'(bus.result), 32'(mon_e.res));
`ifdef EARLY_EXIT_EN
                check("terms_used", 32'(terms_used), 32'(mon_e.terms));
`endif
            end
        end
    end

    // One transaction: accept, optional stimulus jamming in CALC, optional back-pressure in DONE.
    task automatic run(input logic [7:0] x, input logic [15:0] hand_res, input bit use_hand,
                       input int hold, input bit jam, input bit first_chk);
        exp_t        e;
        logic [15:0] g;
        logic [4:0]  it;
        logic [15:0] held;
        int          cnt;
        golden(x, g, it);
        e.res   = use_hand ? hand_res : g;
        e.terms = it;
        check("in_ready_before", 32'(bus.in_ready), 32'd1);
        bus.x_in      = x;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        sb_q.push_back(e);
        if (!jam) bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < TIMEOUT) begin
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            if (jam) bus.x_in = 8'($urandom);
            if (first_chk && cnt == 1) begin
                check("term_after_1", 32'(dut.term_q), 32'h1FE0);
                check("sum_after_1", 32'(dut.sum_q), 32'h5FE0);
            end
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(it) + 32'd1);
        held = bus.result;
        repeat (hold) begin
            @(posedge clk); #1;
            check("result_stable", 32'(bus.result), 32'(held));
            check("in_ready_done", 32'(bus.in_ready), 32'd0);
            check("out_valid_held", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 16; i++) lut[i] = (i == 0) ? 8'hFF : 8'(256 / (i + 1));
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // x=0: every term vanishes, result is exactly 1.0.
        run(8'h00, 16'h4000, 1'b1, 0, 1'b0, 1'b0);
        // x=0.5 with x_in jammed during CALC and in_valid held into DONE.
        run(8'h80, 16'h6958, 1'b1, 0, 1'b1, 1'b1);
        // x near 1.0 with five cycles of back-pressure.
        run(8'hFF, 16'h0, 1'b0, 5, 1'b0, 1'b0);

        // Abort mid-CALC: no output may appear.
        bus.x_in     = 8'h33;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        while (dut.k_q != 5'd3 && cnt < TIMEOUT) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("reach_k3", 32'(dut.k_q), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_result", 32'(bus.result), 32'h0);
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (bus.out_valid) check("abort_no_output", 32'(bus.out_valid), 32'd0);
        end

        run(8'h40, 16'h0, 1'b0, 0, 1'b0, 1'b0);
        run(8'hC3, 16'h0, 1'b0, 2, 1'b0, 1'b0);

`ifdef EARLY_EXIT_EN
        // Second term already truncates to zero: two iterations, sum 1 + 0x3F.
        run(8'h01, 16'h403F, 1'b1, 0, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
